// File: rtl/phase_a_sched_pkg.sv
// Shared types and defaults for the phase_a round-robin scheduler (package phase_a_pkg).
package phase_a_pkg;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_SIZE    = 3072;
  localparam int unsigned DEF_RADIX   = 54;
  localparam int unsigned DEF_TIMEOUT = 255;
  localparam int unsigned ID_W        = $clog2(DEF_NREQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } pa_state_e;

  // Round-robin successor that also handles non-power-of-two requester counts.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/phase_a_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping at N-1.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  int unsigned j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/phase_a_sched.sv
// Round-robin scheduler sharing one phase_a Montgomery-reduction datapath among NREQ requesters.
// Optional watchdog on the WAIT state: define PHASE_A_SCHED_TIMEOUT_EN.
module phase_a_sched
  import phase_a_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned SIZE    = DEF_SIZE,
  parameter int unsigned RADIX   = DEF_RADIX,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_wr,
  input  logic [SIZE-1:0]         cfg_m,
  input  logic [SIZE+1:0]         cfg_m_n,
  input  logic [RADIX+1:0]        cfg_m_prime,
  output logic                    cfg_ready,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*SIZE-1:0]    req_a,
  output logic [NREQ-1:0]         gnt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [SIZE-1:0]         rsp_data,
  output logic                    rsp_err,
  output logic                    pa_en,
  output logic [SIZE-1:0]         pa_a,
  output logic [SIZE-1:0]         pa_m,
  output logic [SIZE+1:0]         pa_m_n,
  output logic [RADIX+1:0]        pa_m_prime,
  input  logic                    pa_en_out,
  input  logic [SIZE-1:0]         pa_new_a
);

  localparam int unsigned IW = $clog2(NREQ);

  pa_state_e       state_q, state_d;
  logic            cfg_valid_q;
  logic [IW-1:0]   ptr_q, id_q;
  logic [NREQ-1:0] gnt_q;
  logic [SIZE-1:0] rsp_data_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [SIZE-1:0] sel_a;
  logic            cfg_load, launch, capture, wd_fire;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // One-hot AND-OR operand mux avoids a variable-width index multiply.
  always_comb begin
    sel_a = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) sel_a = sel_a | req_a[i*SIZE +: SIZE];
    end
  end

  always_comb begin
    state_d  = state_q;
    cfg_load = 1'b0;
    launch   = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_wr) begin
          cfg_load = 1'b1;
        end else if (cfg_valid_q && arb_any) begin
          launch  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (pa_en_out) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (wd_fire) begin
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_valid_q <= 1'b0;
      pa_m        <= '0;
      pa_m_n      <= '0;
      pa_m_prime  <= '0;
      ptr_q       <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      pa_a        <= '0;
      rsp_data_q  <= '0;
    end else begin
      gnt_q <= launch ? arb_gnt : '0;
      if (cfg_load) begin
        cfg_valid_q <= 1'b1;
        pa_m        <= cfg_m;
        pa_m_n      <= cfg_m_n;
        pa_m_prime  <= cfg_m_prime;
      end
      if (launch) begin
        pa_a  <= sel_a;
        id_q  <= arb_idx;
        ptr_q <= IW'(rr_next(32'(arb_idx), NREQ));
      end
      if (capture)      rsp_data_q <= pa_new_a;
      else if (wd_fire) rsp_data_q <= '0;
    end
  end

`ifdef PHASE_A_SCHED_TIMEOUT_EN
  logic [7:0] wd_q;
  logic       rsp_err_q;

  assign wd_fire = (state_q == WAIT) && !pa_en_out && (wd_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_q != WAIT) wd_q <= '0;
      else if (!pa_en_out) wd_q <= wd_q + 8'd1;
      if (capture)      rsp_err_q <= 1'b0;
      else if (wd_fire) rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign wd_fire = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign cfg_ready = (state_q == IDLE);
  assign pa_en     = (state_q == LAUNCH);
  assign rsp_valid = (state_q == RESP);
  assign gnt       = gnt_q;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_phase_a_sched.sv
// Bench for phase_a_sched with a phase_a stub (new_a = a+1, fixed latency) and a transaction-level model.
module tb_phase_a_sched;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned SIZE    = 16;
  localparam int unsigned RADIX   = 6;
  localparam int unsigned TIMEOUT = 255;
  localparam int          L       = 18;

  logic                 clk, rst_n;
  logic                 cfg_wr;
  logic [SIZE-1:0]      cfg_m;
  logic [SIZE+1:0]      cfg_m_n;
  logic [RADIX+1:0]     cfg_m_prime;
  logic                 cfg_ready;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] req_a;
  logic [NREQ-1:0]      gnt;
  logic                 rsp_valid, rsp_ready;
  logic [1:0]           rsp_id;
  logic [SIZE-1:0]      rsp_data;
  logic                 rsp_err;
  logic                 pa_en;
  logic [SIZE-1:0]      pa_a, pa_m;
  logic [SIZE+1:0]      pa_m_n;
  logic [RADIX+1:0]     pa_m_prime;
  logic                 pa_en_out;
  logic [SIZE-1:0]      pa_new_a;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  phase_a_sched #(.NREQ(NREQ), .SIZE(SIZE), .RADIX(RADIX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr(cfg_wr), .cfg_m(cfg_m), .cfg_m_n(cfg_m_n), .cfg_m_prime(cfg_m_prime),
    .cfg_ready(cfg_ready),
    .req(req), .req_a(req_a), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .pa_en(pa_en), .pa_a(pa_a), .pa_m(pa_m), .pa_m_n(pa_m_n), .pa_m_prime(pa_m_prime),
    .pa_en_out(pa_en_out), .pa_new_a(pa_new_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // phase_a stub: on an en rising edge, answer a+1 with en_out L cycles later
  logic            st_prev, st_out, mute, inj;
  int              st_cnt;
  logic [SIZE-1:0] st_a, st_data, inj_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_prev <= 1'b0; st_cnt <= 0; st_out <= 1'b0; st_a <= '0; st_data <= '0;
    end else begin
      st_prev <= pa_en;
      st_out  <= 1'b0;
      if (pa_en && !st_prev) begin
        st_cnt <= 1;
        st_a   <= pa_a;
      end else if (st_cnt == L) begin
        st_cnt <= 0;
        if (!mute) begin
          st_out  <= 1'b1;
          st_data <= st_a + 1'b1;
        end
      end else if (st_cnt != 0) begin
        st_cnt <= st_cnt + 1;
      end
    end
  end

  assign pa_en_out = st_out | inj;
  assign pa_new_a  = inj ? inj_data : st_data;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // en pulse shape: never high two samples in a row, low >=3 samples before each rise
  int   low_run = 100;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      low_run = 100;
      prev_en = 1'b0;
    end else begin
      if (pa_en) begin
        chk("en_pulse_shape", {prev_en, low_run >= 3}, 2'b01);
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_en = pa_en;
    end
  end

  task automatic set_op(input int i, input logic [SIZE-1:0] v);
    req_a[i*SIZE +: SIZE] = v;
  endtask

  int              g_cyc;
  logic [SIZE-1:0] g_op;

  task automatic start_txn(input logic [3:0] rq, input logic [3:0] exp_g,
                           input logic [SIZE-1:0] exp_a, input string nm);
    int n;
    req = rq;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 40);
    chk({nm, "_gnt"}, gnt, exp_g);
    chk({nm, "_pa_en"}, pa_en, 1'b1);
    chk({nm, "_pa_a"}, pa_a, exp_a);
    g_cyc = cyc;
    g_op  = pa_a;
    req   = '0;
  endtask

  task automatic finish_txn(input logic [1:0] exp_id, input logic [SIZE-1:0] exp_d,
                            input logic exp_err, input int exp_lat, input string nm);
    int n;
    n = 0;
    while (!rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, cyc - g_cyc, exp_lat);
    chk({nm, "_rsp_id"}, rsp_id, exp_id);
    chk({nm, "_rsp_data"}, rsp_data, exp_d);
    chk({nm, "_rsp_err"}, rsp_err, exp_err);
    chk({nm, "_pa_a_stable"}, pa_a, g_op);
    if (rsp_ready) begin
      @(negedge clk);
      chk({nm, "_rsp_drop"}, rsp_valid, 1'b0);
    end
  endtask

  function automatic int winner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  typedef struct {
    logic [3:0] rq;
    logic [3:0] g;
    logic [1:0] id;
  } vec_t;

  typedef struct {
    logic [1:0]      id;
    logic [SIZE-1:0] d;
  } rsp_t;

  rsp_t       q[$];
  bit         seen;
  int         ptr_m, ngr;
  logic [3:0] prev_req;
  logic       pend[4];
  logic [SIZE-1:0] opnd[4];

  task automatic rand_gnt_obs();
    int w;
    logic [3:0] eg;
    rsp_t e;
    if (gnt != '0) begin
      w  = winner(prev_req, ptr_m);
      eg = (w < 0) ? 4'b0000 : 4'(1 << w);
      chk("rand_gnt", gnt, eg);
      if (w >= 0) begin
        e.id = 2'(w);
        e.d  = opnd[w] + 1'b1;
        q.push_back(e);
        pend[w] = 1'b0;
        ptr_m   = (w + 1) % 4;
        ngr++;
      end
    end
  endtask

  task automatic rand_rsp_obs();
    rsp_t e;
    if (rsp_valid && !seen) begin
      seen = 1'b1;
      if (q.size() == 0) begin
        chk("rand_rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        e = q.pop_front();
        chk("rand_rsp_id", rsp_id, e.id);
        chk("rand_rsp_data", rsp_data, e.d);
        chk("rand_rsp_err", rsp_err, 1'b0);
      end
    end
  endtask

  task automatic do_cfg(input logic [SIZE-1:0] m, input logic [SIZE+1:0] mn,
                        input logic [RADIX+1:0] mp);
    cfg_m = m; cfg_m_n = mn; cfg_m_prime = mp; cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  vec_t tbl[11];
  logic [82:0] zero_outs;

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit flag;
    int n, prev_g;
    logic [SIZE-1:0] ea;

    tbl[0]  = '{4'b1111, 4'b0010, 2'd1};
    tbl[1]  = '{4'b1111, 4'b0100, 2'd2};
    tbl[2]  = '{4'b1111, 4'b1000, 2'd3};
    tbl[3]  = '{4'b1111, 4'b0001, 2'd0};
    tbl[4]  = '{4'b0001, 4'b0001, 2'd0};
    tbl[5]  = '{4'b0100, 4'b0100, 2'd2};
    tbl[6]  = '{4'b0011, 4'b0001, 2'd0};
    tbl[7]  = '{4'b1000, 4'b1000, 2'd3};
    tbl[8]  = '{4'b0110, 4'b0010, 2'd1};
    tbl[9]  = '{4'b1001, 4'b1000, 2'd3};
    tbl[10] = '{4'b1110, 4'b0010, 2'd1};

    rst_n = 1'b0; cfg_wr = 1'b0; cfg_m = '0; cfg_m_n = '0; cfg_m_prime = '0;
    req = '0; req_a = '0; rsp_ready = 1'b1; mute = 1'b0; inj = 1'b0; inj_data = '0;
    repeat (3) @(negedge clk);
    zero_outs = {gnt, rsp_valid, rsp_id, rsp_data, rsp_err, pa_en, pa_a, pa_m, pa_m_n, pa_m_prime};
    chk("reset_outs", zero_outs, '0);
    chk("reset_cfg_ready", cfg_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // request before any config must wait
    set_op(0, 16'd5);
    req  = 4'b0001;
    flag = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (gnt != '0) flag = 1'b1;
    end
    chk("precfg_nogrant", flag, 1'b0);
    do_cfg(16'h1234, 18'h2EDCC, 8'h5B);
    chk("cfg_cycle_nogrant", gnt, 4'b0000);
    chk("cfg_load", {pa_m, pa_m_n, pa_m_prime}, {16'h1234, 18'h2EDCC, 8'h5B});
    start_txn(4'b0001, 4'b0001, 16'd5, "first");
    finish_txn(2'd0, 16'd6, 1'b0, L + 2, "first");

    // table: round-robin order and back-to-back throughput
    for (int t = 0; t < 11; t++) begin
      for (int i = 0; i < 4; i++) set_op(i, 16'(t * 256 + i * 16 + 3));
      ea     = 16'(t * 256 + int'(tbl[t].id) * 16 + 3);
      prev_g = g_cyc;
      start_txn(tbl[t].rq, tbl[t].g, ea, $sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d_period", t), g_cyc - prev_g, L + 4);
      finish_txn(tbl[t].id, ea + 1'b1, 1'b0, L + 2, $sformatf("tbl%0d", t));
    end

    // cfg_wr while the datapath is busy is dropped
    set_op(2, 16'hA5A5);
    start_txn(4'b0100, 4'b0100, 16'hA5A5, "cfgwait");
    repeat (3) @(negedge clk);
    chk("cfgwait_ready", cfg_ready, 1'b0);
    do_cfg(16'hBEEF, 18'h1, 8'h1);
    chk("cfgwait_dropped", {pa_m, pa_m_n, pa_m_prime}, {16'h1234, 18'h2EDCC, 8'h5B});
    finish_txn(2'd2, 16'hA5A6, 1'b0, L + 2, "cfgwait");
    chk("cfgwait_after", {pa_m, pa_m_n, pa_m_prime}, {16'h1234, 18'h2EDCC, 8'h5B});
    do_cfg(16'hBEEF, 18'h1, 8'h1);
    chk("cfg_reload", {pa_m, pa_m_n, pa_m_prime}, {16'hBEEF, 18'h1, 8'h1});

    // response back-pressure
    rsp_ready = 1'b0;
    set_op(0, 16'h0F0F);
    start_txn(4'b0001, 4'b0001, 16'h0F0F, "hold");
    set_op(1, 16'h7777);
    req = 4'b0010;
    finish_txn(2'd0, 16'h0F10, 1'b0, L + 2, "hold");
    flag = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== 16'h0F10 || rsp_id !== 2'd0 || gnt !== 4'b0000) flag = 1'b0;
    end
    chk("hold_stable", flag, 1'b1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", rsp_valid, 1'b0);
    start_txn(4'b0010, 4'b0010, 16'h7777, "after_hold");
    finish_txn(2'd1, 16'h7778, 1'b0, L + 2, "after_hold");

    // en_out outside WAIT is ignored
    inj_data = 16'hDEAD;
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("spurious_en_out", {rsp_valid, cfg_ready}, 2'b01);

    // reset in the middle of an operation
    set_op(2, 16'h3333);
    start_txn(4'b0100, 4'b0100, 16'h3333, "rst");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    zero_outs = {gnt, rsp_valid, rsp_id, rsp_data, rsp_err, pa_en, pa_a, pa_m, pa_m_n, pa_m_prime};
    chk("midrst_outs", zero_outs, '0);
    chk("midrst_cfg_ready", cfg_ready, 1'b1);
    rst_n = 1'b1;
    req  = 4'b0001;
    flag = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (gnt != '0 || rsp_valid) flag = 1'b1;
    end
    chk("postrst_idle", flag, 1'b0);
    do_cfg(16'h1234, 18'h2EDCC, 8'h5B);
    set_op(1, 16'h4444);
    start_txn(4'b1010, 4'b0010, 16'h4444, "restart");
    finish_txn(2'd1, 16'h4445, 1'b0, L + 2, "restart");

`ifdef PHASE_A_SCHED_TIMEOUT_EN
    mute = 1'b1;
    set_op(3, 16'h5555);
    start_txn(4'b1000, 4'b1000, 16'h5555, "wdog");
    finish_txn(2'd3, 16'h0000, 1'b1, int'(TIMEOUT) + 1, "wdog");
    mute = 1'b0;
    set_op(0, 16'h0100);
    start_txn(4'b0001, 4'b0001, 16'h0100, "after_wdog");
    finish_txn(2'd0, 16'h0101, 1'b0, L + 2, "after_wdog");
`endif

    // randomized traffic against the transaction model, from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_cfg(16'h1234, 18'h2EDCC, 8'h5B);
    ptr_m = 0; ngr = 0; seen = 1'b0; prev_req = '0;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0;
      opnd[i] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rand_gnt_obs();
      rand_rsp_obs();
      rsp_ready = ($urandom % 3) != 0;
      if (rsp_valid && rsp_ready) seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (pend[i] && ($urandom % 40) == 0) begin
          pend[i] = 1'b0;
        end else if (!pend[i] && ($urandom % 6) == 0) begin
          pend[i] = 1'b1;
          opnd[i] = 16'($urandom);
        end
        req[i] = pend[i];
        set_op(i, opnd[i]);
      end
      prev_req = req;
    end
    req = '0;
    rsp_ready = 1'b1;
    if (rsp_valid) seen = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      rand_gnt_obs();
      prev_req = '0;
      rand_rsp_obs();
      if (rsp_valid) seen = 1'b0;
      n++;
    end while ((q.size() != 0 || !cfg_ready) && n < 200);
    chk("rand_drain", q.size(), 0);
    chk("rand_activity", ngr > 20, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
